data_mem_responder: RTL

- Responder (memory side) of the MEM-stage load/store request interface in the pipelined RISC-V core.
- Accepts one request at a time over a valid/ready request channel.
- Performs a byte, halfword or word access to an internal word-organised, little-endian RAM after a fixed programmable latency.
- Returns data and error status over a valid/ready response channel.

---
 rtl/mem_pkg.sv | 55 +++++
 rtl/data_mem_responder_load_extend.sv | 37 +++
 rtl/data_mem_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder: access sizes, FSM states,
// the captured request record and the fault / byte-enable decoders.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } access_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    typedef struct packed {
        logic         we;
        logic [31:0]  addr;
        access_size_e size;
        logic         uns;
        logic         err;
    } mem_req_t;

    // Misaligned, illegal-size or out-of-range accesses fault and never touch the RAM.
    function automatic logic access_fault(input logic [31:0] addr,
                                          input access_size_e size,
                                          input int unsigned depth);
        logic fault;
        case (size)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = addr[0];
            SZ_WORD: fault = (addr[1:0] != 2'b00);
            default: fault = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= depth) begin
            fault = 1'b1;
        end
        return fault;
    endfunction

    function automatic logic [3:0] byte_enables(input access_size_e size,
                                                input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_mem_responder_load_extend.sv
// Lane select and sign/zero extension of a little-endian RAM word for byte,
// halfword and word loads.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0]  word,
    input  logic [1:0]   lane,
    input  access_size_e size,
    input  logic         uns,
    output logic [31:0]  data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = 8'h00;
        case (lane)
            2'd0: byte_val = word[7:0];
            2'd1: byte_val = word[15:8];
            2'd2: byte_val = word[23:16];
            default: byte_val = word[31:24];
        endcase
        half_val = lane[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = 32'h0000_0000;
        case (size)
            SZ_BYTE: data = uns ? {24'h000000, byte_val} : {{24{byte_val[7]}}, byte_val};
            SZ_HALF: data = uns ? {16'h0000, half_val} : {{16{half_val[15]}}, half_val};
            SZ_WORD: data = word;
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for MEM-stage loads/stores: one request at a time, fixed
// programmable latency, word-organised little-endian RAM, error reporting.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    logic [31:0] mem [DEPTH];

    state_e      state_reg;
    mem_req_t    req_reg;
    logic [3:0]  cnt_reg;
    logic        req_ready_reg;
    logic        rsp_valid_reg;
    logic        rsp_err_reg;
    logic        load_ok_reg;
    logic [31:0] word_reg;

    mem_req_t    req_next;
    mem_req_t    resp_req;
    logic        accept;
    logic        enter_resp;
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [31:0] lane_data;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0] ext_data;
    logic        unused_bits;

    always_comb begin
        req_next.we   = req_we;
        req_next.addr = req_addr;
        req_next.size = access_size_e'(req_size);
        req_next.uns  = req_unsigned;
        req_next.err  = access_fault(req_addr, access_size_e'(req_size), DEPTH);
    end

    assign accept = (state_reg == ST_IDLE) && req_valid;

    // With LATENCY = 1 the response is formed on the acceptance edge from the live request.
    assign resp_req   = (state_reg == ST_IDLE) ? req_next : req_reg;
    assign enter_resp = !reset && (((LATENCY == 1) && accept) ||
                                   ((state_reg == ST_WAIT) && (cnt_reg == 4'd0)));

    assign wr_en  = !reset && accept && req_we && !req_next.err;
    assign wr_be  = byte_enables(req_next.size, req_addr[1:0]);
    assign wr_idx = req_addr[IDX_W+1:2];
    assign rd_idx = resp_req.addr[IDX_W+1:2];

    assign unused_bits = ^{resp_req.addr[31:IDX_W+2], resp_req.addr[1:0],
                           resp_req.size, resp_req.uns};

    // Store data is right-aligned; replicate it onto every lane it could land in.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_data[8*gi +: 8] =
                (req_next.size == SZ_BYTE) ? req_wdata[7:0] :
                (req_next.size == SZ_HALF) ? req_wdata[8*(gi%2) +: 8] :
                                             req_wdata[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= lane_data[8*b +: 8];
                end
            end
        end
        if (enter_resp) begin
            word_reg <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            req_reg       <= '0;
            cnt_reg       <= 4'd0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            load_ok_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_reg       <= req_next;
                        req_ready_reg <= 1'b0;
                        cnt_reg       <= CNT_INIT;
                        if (LATENCY == 1) begin
                            state_reg     <= ST_RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= req_next.err;
                            load_ok_reg   <= !req_next.we && !req_next.err;
                        end else begin
                            state_reg <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg     <= ST_RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= req_reg.err;
                        load_ok_reg   <= !req_reg.we && !req_reg.err;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= ST_IDLE;
                        req_ready_reg <= 1'b1;
                        rsp_valid_reg <= 1'b0;
                        rsp_err_reg   <= 1'b0;
                        load_ok_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                    rsp_err_reg   <= 1'b0;
                    load_ok_reg   <= 1'b0;
                end
            endcase
        end
    end

    load_extend u_load_extend (
        .word (word_reg),
        .lane (req_reg.addr[1:0]),
        .size (req_reg.size),
        .uns  (req_reg.uns),
        .data (ext_data)
    );

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = load_ok_reg ? ext_data : 32'h0000_0000;

endmodule
